// File: rtl/cordic_vec_postproc_pkg.sv
// rtl/cordic_vec_postproc_pkg.sv - shared constants, tag encodings and FSM states for the CORDIC vectoring post-processor
package cordic_vec_postproc_pkg;

    localparam int FRAC   = 11;
    localparam int K_INV  = 1244;
    localparam int PI     = 6434;
    localparam int TWO_PI = 2 * PI;

    // quad_in bit positions from the pre-rotation stage
    localparam int QUAD_CORR_BIT = 1;
    localparam int QUAD_SIGN_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_shift_add_mul.sv
// rtl/cordic_shift_add_mul.sv - sequential unsigned shift-add multiply by a constant, one operand bit per clock
module cordic_shift_add_mul #(
    parameter int          W = 16,
    parameter logic [W-1:0] K = 16'd1244
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   op_in,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W);

    logic [W-1:0]   op;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] addend;
    logic [2*W-1:0] acc_next;
    logic [CW-1:0]  cnt;

    assign addend   = op[0] ? ({{W{1'b0}}, K} << cnt) : '0;
    assign acc_next = acc + addend;
    // done and product look one step ahead so the caller can capture the final sum on the last edge
    assign done     = busy && (cnt == CW'(W - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            op   <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            op   <= op_in;
            acc  <= '0;
            cnt  <= '0;
        end else if (busy) begin
            acc <= acc_next;
            op  <= op >> 1;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cordic_vec_postproc.sv
// rtl/cordic_vec_postproc.sv - gain-compensated magnitude and full-range phase from the last vectoring CORDIC stage
module cordic_vec_postproc
    import cordic_vec_postproc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] theta_in,
    input  logic [1:0]              quad_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] mag_out,
    output logic signed [WIDTH-1:0] phase_out
);

    localparam int PW = WIDTH + 2;
    localparam logic signed [PW-1:0] PI_W     = PW'(PI);
    localparam logic signed [PW-1:0] TWO_PI_W = PW'(TWO_PI);
    localparam logic [2*WIDTH-1:0]   HALF_LSB = (2*WIDTH)'(1) << (FRAC - 1);
    localparam logic [2*WIDTH-1:0]   MAG_MAX  = (2*WIDTH)'((1 << (WIDTH - 1)) - 1);

    state_t state, next_state;

    logic                 mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0]     op_in;
    logic [2*WIDTH-1:0]   product, rounded, shifted;
    logic [WIDTH-1:0]     mag_sat;
    logic signed [PW-1:0] theta_ext, corr, t_raw, t_wrap;
    logic [WIDTH-1:0]     phase_pend;

    // negative X means the vector never reached the positive half-plane: clamp to zero
    assign op_in = x_in[WIDTH-1] ? '0 : x_in;

    cordic_shift_add_mul #(
        .W (WIDTH),
        .K (WIDTH'(K_INV))
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op_in   (op_in),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    assign rounded = product + HALF_LSB;
    assign shifted = rounded >> FRAC;
    assign mag_sat = (shifted > MAG_MAX) ? WIDTH'(MAG_MAX) : WIDTH'(shifted);

    always_comb begin
        theta_ext = {{2{theta_in[WIDTH-1]}}, theta_in};
        corr      = '0;
        if (quad_in[QUAD_CORR_BIT]) begin
            corr = quad_in[QUAD_SIGN_BIT] ? -PI_W : PI_W;
        end
        t_raw  = theta_ext + corr;
        t_wrap = t_raw;
        if (t_raw > PI_W) begin
            t_wrap = t_raw - TWO_PI_W;
        end else if (t_raw <= -PI_W) begin
            t_wrap = t_raw + TWO_PI_W;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !mul_busy;
                if (in_valid && !mul_busy) begin
                    mul_start  = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            mag_out    <= '0;
            phase_out  <= '0;
            phase_pend <= '0;
        end else begin
            state <= next_state;
            if (mul_start) begin
                phase_pend <= WIDTH'(t_wrap);
            end
            if (state == ST_BUSY && mul_done) begin
                mag_out   <= mag_sat;
                phase_out <= phase_pend;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vec_postproc.sv
// tb/tb_cordic_vec_postproc.sv - randomized self-checking bench for cordic_vec_postproc
module tb_cordic_vec_postproc;

    localparam int WIDTH = 16;
    localparam int PI    = 6434;
    localparam int K_INV = 1244;
    localparam int FRAC  = 11;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] theta_in = '0;
    logic [1:0]              quad_in = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [WIDTH-1:0] mag_out;
    logic signed [WIDTH-1:0] phase_out;

    int checks = 0;
    int errors = 0;

    cordic_vec_postproc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .theta_in  (theta_in),
        .quad_in   (quad_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .phase_out (phase_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_mag(input int x);
        longint p;
        if (x < 0) return 0;
        p = (longint'(x) * K_INV + (1 << (FRAC - 1))) / (1 << FRAC);
        if (p > 32767) p = 32767;
        return p;
    endfunction

    function automatic longint ref_phase(input int th, input logic [1:0] q);
        int t;
        logic signed [WIDTH-1:0] tr;
        t = th;
        if (q[1]) t = t + (q[0] ? -PI : PI);
        if (t > PI) t = t - 2 * PI;
        else if (t <= -PI) t = t + 2 * PI;
        tr = t[WIDTH-1:0];
        return longint'(tr);
    endfunction

    function automatic int rand_x();
        if ($urandom_range(0, 3) == 0) return -int'($urandom_range(1, 32768));
        return int'($urandom_range(0, 32767));
    endfunction

    function automatic int rand_theta();
        return int'($urandom_range(0, 2 * PI)) - PI;
    endfunction

    task automatic run_sample(input int x, input int th, input logic [1:0] q, input int hold);
        int lat;
        longint em, ep;
        em = ref_mag(x);
        ep = ref_phase(th, q);
        @(negedge clk);
        x_in = WIDTH'(x); theta_in = WIDTH'(th); quad_in = q;
        in_valid = 1'b1; out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, 16);
        check("mag", mag_out, em);
        check("phase", phase_out, ep);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x_in = WIDTH'(rand_x()); theta_in = WIDTH'(rand_theta()); quad_in = 2'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_mag", mag_out, em);
            check("hold_phase", phase_out, ep);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint exp_mag[$];
        longint exp_phase[$];
        int n_acc, n_out, last_acc;
        bit accepted;
        int cx, ct;
        logic [1:0] cq;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mag", mag_out, 0);
        check("rst_phase", phase_out, 0);

        run_sample(2048, 0, 2'b00, 0);
        run_sample(32767, 1024, 2'b10, 10);
        check("tp2_mag_const", mag_out, 19903);
        check("tp2_phase_const", phase_out, -5410);

        // reset during BUSY discards the sample and zeroes the outputs
        @(negedge clk);
        x_in = 16'sd1000; theta_in = 16'sd100; quad_in = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_mag", mag_out, 0);
        check("midrst_phase", phase_out, 0);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b1;

        run_sample(-5, -1024, 2'b11, 2);
        check("tp3_phase_const", phase_out, 5410);

        for (int i = 0; i < 6; i++) begin
            run_sample(rand_x(), rand_theta(), 2'($urandom), int'($urandom_range(0, 3)));
        end

        // back-to-back: in_valid held high, downstream always ready
        n_acc = 0; n_out = 0; last_acc = -1; accepted = 1'b0;
        @(negedge clk);
        cx = rand_x(); ct = rand_theta(); cq = 2'($urandom);
        x_in = WIDTH'(cx); theta_in = WIDTH'(ct); quad_in = cq;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 400 && n_out < 8; k++) begin
            if (out_valid) begin
                if (exp_mag.size() == 0) begin
                    check("b2b_spurious_output", 1, 0);
                end else begin
                    check("b2b_mag", mag_out, exp_mag.pop_front());
                    check("b2b_phase", phase_out, exp_phase.pop_front());
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_mag.push_back(ref_mag(cx));
                exp_phase.push_back(ref_phase(ct, cq));
                if (last_acc >= 0) check("b2b_period", k - last_acc, WIDTH + 2);
                last_acc = k;
                n_acc++;
                accepted = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (accepted) begin
                accepted = 1'b0;
                if (n_acc < 8) begin
                    cx = rand_x(); ct = rand_theta(); cq = 2'($urandom);
                    x_in = WIDTH'(cx); theta_in = WIDTH'(ct); quad_in = cq;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_outputs", n_out, 8);
        check("b2b_leftover", exp_mag.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
